// File: rtl/peak_pkg.sv
// Shared constants for the window peak tracker: FSM encoding and default widths.
package peak_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int WIN_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

endpackage

// File: rtl/window_peak_tracker_if.sv
// Sample-in / result-out handshake bundle; slave is the tracker, master the environment.
interface window_peak_tracker_if
    import peak_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic [CNT_W-1:0]  out_max_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_max_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_min, out_max_cnt
    );

endinterface

// File: rtl/mag_cmp_unit.sv
// Combinational unsigned magnitude comparator: a against b.
module mag_cmp_unit #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/window_peak_tracker.sv
// Tracks max, min and count-of-max over fixed windows of accepted samples and
// reports one registered result per window through a valid/ready handshake.
module window_peak_tracker
    import peak_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    window_peak_tracker_if.slave bus
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  sample_cnt;
    logic [DATA_W-1:0] cur_max;
    logic [DATA_W-1:0] cur_min;
    logic [CNT_W-1:0]  max_cnt;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_max_q;
    logic [DATA_W-1:0] out_min_q;
    logic [CNT_W-1:0]  out_max_cnt_q;

    logic              accept;
    logic              last_sample;
    logic              gt_max, eq_max, lt_min;
    logic              cmp_unused_lt_max, cmp_unused_gt_min, cmp_unused_eq_min;
    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;
    logic [CNT_W-1:0]  nxt_cnt;

    mag_cmp_unit #(.DATA_W(DATA_W)) u_cmp_max (
        .a  (bus.in_data),
        .b  (cur_max),
        .gt (gt_max),
        .lt (cmp_unused_lt_max),
        .eq (eq_max)
    );

    mag_cmp_unit #(.DATA_W(DATA_W)) u_cmp_min (
        .a  (bus.in_data),
        .b  (cur_min),
        .gt (cmp_unused_gt_min),
        .lt (lt_min),
        .eq (cmp_unused_eq_min)
    );

    assign bus.in_ready    = (state != ST_REPORT);
    assign accept          = bus.in_valid && bus.in_ready;
    assign last_sample     = (sample_cnt == CNT_W'(WIN_LEN - 1));

    assign bus.out_valid   = out_valid_q;
    assign bus.out_max     = out_max_q;
    assign bus.out_min     = out_min_q;
    assign bus.out_max_cnt = out_max_cnt_q;

    // The first sample of a window seeds all three statistics; later ones compare
    // against the registered values, with max and min updated independently.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        nxt_max = cur_max;
        nxt_min = cur_min;
        nxt_cnt = max_cnt;
        if (state == ST_IDLE) begin
            nxt_max = bus.in_data;
            nxt_min = bus.in_data;
            nxt_cnt = CNT_W'(1);
        end else begin
            if (gt_max) begin
                nxt_max = bus.in_data;
                nxt_cnt = CNT_W'(1);
            end else if (eq_max) begin
                nxt_cnt = max_cnt + CNT_W'(1);
            end
            if (lt_min) nxt_min = bus.in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sample_cnt    <= '0;
            cur_max       <= '0;
            cur_min       <= '0;
            max_cnt       <= '0;
            out_valid_q   <= 1'b0;
            out_max_q     <= '0;
            out_min_q     <= '0;
            out_max_cnt_q <= '0;
        end else if (clear) begin
            // Abort wins over everything; the last reported values stay visible.
            state       <= ST_IDLE;
            sample_cnt  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_ACCUM;
                        sample_cnt <= CNT_W'(1);
                        cur_max    <= nxt_max;
                        cur_min    <= nxt_min;
                        max_cnt    <= nxt_cnt;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        cur_max    <= nxt_max;
                        cur_min    <= nxt_min;
                        max_cnt    <= nxt_cnt;
                        if (last_sample) begin
                            state         <= ST_REPORT;
                            out_valid_q   <= 1'b1;
                            out_max_q     <= nxt_max;
                            out_min_q     <= nxt_min;
                            out_max_cnt_q <= nxt_cnt;
                        end
                    end
                end
                ST_REPORT: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        sample_cnt  <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_peak_tracker.sv
// Directed-vector bench for window_peak_tracker: one task per scenario.
module tb_window_peak_tracker;

    typedef logic [3:0] win_t [8];

    logic clk;
    logic rst_n;
    logic clear;
    int   total;
    int   passed;

    window_peak_tracker_if #(.DATA_W(4), .CNT_W(4)) bus ();

    window_peak_tracker #(.DATA_W(4), .WIN_LEN(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample, wait (bounded) for in_ready, and let one edge accept it.
    task automatic push(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            $display("FAIL push_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic push_n(input win_t w, input int n);
        for (int i = 0; i < n; i++) push(w[i]);
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passed++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else passed++;
        if (bus.out_max !== 4'd0) $display("FAIL reset_max: got %0d want 0", bus.out_max); else passed++;
        if (bus.out_min !== 4'd0) $display("FAIL reset_min: got %0d want 0", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", bus.out_max_cnt); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_window();
        win_t w;
        w = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd4, 4'd0, 4'd15, 4'd7};
        push_n(w, 7);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); else passed++;
        push(w[7]);
        total += 5;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd15) $display("FAIL basic_max: got %0d want 15", bus.out_max); else passed++;
        if (bus.out_min !== 4'd0) $display("FAIL basic_min: got %0d want 0", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd1) $display("FAIL basic_cnt: got %0d want 1", bus.out_max_cnt); else passed++;
        if (bus.in_ready !== 1'b0) $display("FAIL basic_report_ready: got %b want 0", bus.in_ready); else passed++;
        take();
        total += 2;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_drop: got %b want 0", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd15) $display("FAIL basic_hold_max: got %0d want 15", bus.out_max); else passed++;
    endtask

    task automatic test_back_to_back();
        win_t w;
        w = '{default: 4'd5};
        push_n(w, 8);
        total += 4;
        if (bus.out_valid !== 1'b1) $display("FAIL uniform_valid: got %b want 1", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd5) $display("FAIL uniform_max: got %0d want 5", bus.out_max); else passed++;
        if (bus.out_min !== 4'd5) $display("FAIL uniform_min: got %0d want 5", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd8) $display("FAIL uniform_cnt: got %0d want 8", bus.out_max_cnt); else passed++;
        take();
        w = '{4'd9, 4'd9, 4'd2, 4'd9, 4'd9, 4'd1, 4'd9, 4'd9};
        push_n(w, 8);
        total += 4;
        if (bus.out_valid !== 1'b1) $display("FAIL mixed_valid: got %b want 1", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd9) $display("FAIL mixed_max: got %0d want 9", bus.out_max); else passed++;
        if (bus.out_min !== 4'd1) $display("FAIL mixed_min: got %0d want 1", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd6) $display("FAIL mixed_cnt: got %0d want 6", bus.out_max_cnt); else passed++;
        take();
    endtask

    task automatic test_backpressure();
        win_t w;
        bit   stable;
        w = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        push_n(w, 8);
        total++;
        if (bus.out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", bus.out_valid); else passed++;
        stable = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd15;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_max !== 4'd8 ||
                bus.out_min !== 4'd1 || bus.out_max_cnt !== 4'd1) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1)
            $display("FAIL bp_stable: ready=%b valid=%b max=%0d min=%0d cnt=%0d want 0/1/8/1/1",
                     bus.in_ready, bus.out_valid, bus.out_max, bus.out_min, bus.out_max_cnt);
        else passed++;
        bus.in_valid = 1'b0;
        take();
        w = '{4'd4, 4'd7, 4'd7, 4'd3, 4'd7, 4'd2, 4'd7, 4'd5};
        push_n(w, 7);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_early_valid: got %b want 0", bus.out_valid); else passed++;
        push(w[7]);
        total += 4;
        if (bus.out_valid !== 1'b1) $display("FAIL bp_next_valid: got %b want 1", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd7) $display("FAIL bp_next_max: got %0d want 7", bus.out_max); else passed++;
        if (bus.out_min !== 4'd2) $display("FAIL bp_next_min: got %0d want 2", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd4) $display("FAIL bp_next_cnt: got %0d want 4", bus.out_max_cnt); else passed++;
        take();
    endtask

    task automatic test_clear();
        win_t w;
        w = '{4'd12, 4'd13, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        push_n(w, 3);
        // Sample 15 presented together with clear must be dropped.
        @(negedge clk);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd15;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        w = '{default: 4'd2};
        push_n(w, 7);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL clear_early_valid: got %b want 0", bus.out_valid); else passed++;
        push(w[7]);
        total += 4;
        if (bus.out_valid !== 1'b1) $display("FAIL clear_valid: got %b want 1", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd2) $display("FAIL clear_max: got %0d want 2", bus.out_max); else passed++;
        if (bus.out_min !== 4'd2) $display("FAIL clear_min: got %0d want 2", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd8) $display("FAIL clear_cnt: got %0d want 8", bus.out_max_cnt); else passed++;
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        total += 2;
        if (bus.out_valid !== 1'b0) $display("FAIL clear_report_drop: got %b want 0", bus.out_valid); else passed++;
        if (bus.in_ready !== 1'b1) $display("FAIL clear_report_ready: got %b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_async_reset();
        win_t w;
        w = '{4'd6, 4'd6, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        push_n(w, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total += 5;
        if (bus.out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", bus.out_valid); else passed++;
        if (bus.in_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", bus.in_ready); else passed++;
        if (bus.out_max !== 4'd0) $display("FAIL arst_max: got %0d want 0", bus.out_max); else passed++;
        if (bus.out_min !== 4'd0) $display("FAIL arst_min: got %0d want 0", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd0) $display("FAIL arst_cnt: got %0d want 0", bus.out_max_cnt); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        w = '{4'd10, 4'd3, 4'd10, 4'd10, 4'd8, 4'd3, 4'd9, 4'd10};
        push_n(w, 7);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL arst_early_valid: got %b want 0", bus.out_valid); else passed++;
        push(w[7]);
        total += 4;
        if (bus.out_valid !== 1'b1) $display("FAIL arst_win_valid: got %b want 1", bus.out_valid); else passed++;
        if (bus.out_max !== 4'd10) $display("FAIL arst_win_max: got %0d want 10", bus.out_max); else passed++;
        if (bus.out_min !== 4'd3) $display("FAIL arst_win_min: got %0d want 3", bus.out_min); else passed++;
        if (bus.out_max_cnt !== 4'd4) $display("FAIL arst_win_cnt: got %0d want 4", bus.out_max_cnt); else passed++;
        take();
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_window();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
